dmem_bridge: RTL and testbench

- Sits downstream of the single-cycle core's data port and consumes its address, write data, MemOp and write-enable.
- Converts each access into a valid/ready request/response transaction against a word-wide synchronous SRAM with per-byte write enables and a fixed read latency.
- Handles byte and halfword lane steering, load sign/zero extension, and an optional alignment check.
- Intended to replace the core's zero-latency data memory so multi-cycle memories and later a stall-capable core can be supported.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_bridge.sv | 163 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: MemOp encodings, FSM states
// and request-legality helpers. The alignment helper is only consulted when
// the design is built with DMEM_ALIGN_CHECK_EN defined.
package dmem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Stores only know signed widths; loads additionally allow the unsigned forms.
    function automatic logic memop_illegal(input logic [2:0] memop, input logic we);
        logic bad;
        if (we)
            bad = !(memop inside {MEMOP_B, MEMOP_H, MEMOP_W});
        else
            bad = !(memop inside {MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU});
        return bad;
    endfunction

    // Halfwords must sit on even bytes, words on multiples of four.
    function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (memop == MEMOP_H || memop == MEMOP_HU)
            bad = off[0];
        else if (memop == MEMOP_W)
            bad = (off != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the bridge. Purely combinational, two independent
// paths: the store path builds byte enables and lane-replicated write data,
// the load path picks the addressed byte/halfword and extends it.
// Misaligned low address bits are masked (halfword uses off[1], word ignores off).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_memop,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    input  logic [2:0]  ld_memop,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    // Store path: enables follow the address, data is replicated to every lane.
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = 32'h0;
        case (st_memop)
            MEMOP_B: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            MEMOP_H: begin
                st_be        = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            MEMOP_W: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: ;
        endcase
    end

    // Load path: sign-extend lb/lh, zero-extend lbu/lhu, pass lw through.
    always_comb begin
        ld_data = 32'h0;
        case (ld_memop)
            MEMOP_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEMOP_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEMOP_W:  ld_data = ld_rdata;
            MEMOP_BU: ld_data = {24'h0, ld_byte};
            MEMOP_HU: ld_data = {16'h0, ld_half};
            default:  ;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the core's zero-latency data port to a word-wide synchronous
// SRAM with byte enables and MEM_LATENCY cycles of read latency.
// Every output is a flop; the next-state block computes the value each output
// takes in the following cycle, so ISSUE-cycle SRAM controls are derived from
// the request inputs at the accept edge.
// Optional build macro: DMEM_ALIGN_CHECK_EN rejects misaligned halfword/word
// accesses instead of masking the low address bits.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_memop,
    input  logic              req_we,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic [1:0]        off_q, off_n;
    logic [2:0]        memop_q, memop_n;
    logic              we_q, we_n;

    logic              req_ready_n, resp_valid_n, resp_err_n, mem_en_n;
    logic [31:0]       resp_rdata_n, mem_wdata_n;
    logic [3:0]        mem_be_n;
    logic [ADDR_W-1:0] mem_addr_n;

    logic              req_bad;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    // Byte address bits above the SRAM word address are don't-care.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_bad = memop_illegal(req_memop, req_we) | misaligned(req_memop, req_addr[1:0]);
`else
    assign req_bad = memop_illegal(req_memop, req_we);
`endif

    dmem_lane_align u_lane (
        .st_memop     (req_memop),
        .st_off       (req_addr[1:0]),
        .st_wdata     (req_wdata),
        .ld_memop     (memop_q),
        .ld_off       (off_q),
        .ld_rdata     (mem_rdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata),
        .ld_data      (ld_data)
    );

    // State, latched request fields and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            off_q      <= '0;
            memop_q    <= '0;
            we_q       <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            off_q      <= off_n;
            memop_q    <= memop_n;
            we_q       <= we_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            mem_en     <= mem_en_n;
            mem_be     <= mem_be_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
        end
    end

    // Next state plus the value every output holds in the next cycle.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        off_n        = off_q;
        memop_n      = memop_q;
        we_n         = we_q;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        mem_en_n     = 1'b0;
        mem_be_n     = '0;
        mem_wdata_n  = '0;
        mem_addr_n   = mem_addr;
        case (state)
            IDLE: begin
                // req_ready is also low for the first cycle out of reset.
                if (req_valid && req_ready) begin
                    off_n   = req_addr[1:0];
                    memop_n = req_memop;
                    we_n    = req_we;
                    if (req_bad) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n    = ISSUE;
                        mem_en_n   = 1'b1;
                        mem_addr_n = req_addr[ADDR_W+1:2];
                        if (req_we) begin
                            mem_be_n    = st_be;
                            mem_wdata_n = st_wdata;
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                end else begin
                    state_n = WAIT;
                    cnt_n   = 2'(MEM_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = ld_data;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        req_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: behavioural SRAM with LAT-cycle read
// latency, a shadow memory model and a response scoreboard.
module tb_dmem_bridge;

    localparam int AW  = 14;
    localparam int LAT = 3;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [2:0]    req_memop = '0;
    logic          req_we = 1'b0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_en;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb_q[$];

    logic [31:0] sram   [0:255];
    logic [31:0] shadow [0:255];
    logic [31:0] rd_pipe [0:LAT-1];

    localparam logic [31:0] LX_ADDR [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
    localparam logic [2:0]  LX_OP   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b010};
    localparam logic [31:0] LX_EXP  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                                            32'hFFFF80FF, 32'h0000007F, 32'h80FF7F01};

    dmem_bridge #(.ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_memop(req_memop), .req_we(req_we),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // SRAM: read-before-write, read data emerges LAT cycles after the strobe.
    always @(posedge clock) begin
        if (mem_en) begin
            rd_pipe[0] <= sram[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Scoreboard: every response must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got rdata=%h err=%b want=no response", resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL sb_resp got rdata=%h err=%b want rdata=%h err=%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    function automatic bit b_illegal(input logic [2:0] op, input logic we);
        if (we) return op > 3'd2;
        return op == 3'd3 || op == 3'd6 || op == 3'd7;
    endfunction

    function automatic bit b_misaligned(input logic [2:0] op, input logic [1:0] off);
        if (op == 3'd1 || op == 3'd5) return off[0];
        if (op == 3'd2) return off != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] b_load(input logic [31:0] w, input logic [2:0] op, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            3'd0: return {{24{b[7]}}, b};
            3'd1: return {{16{h[15]}}, h};
            3'd2: return w;
            3'd4: return {24'h0, b};
            3'd5: return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] b_store(input logic [31:0] w, input logic [2:0] op,
                                            input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (op)
            3'd0: r[8*off +: 8] = wd[7:0];
            3'd1: if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            3'd2: r = wd;
            default: ;
        endcase
        return r;
    endfunction

    function automatic exp_t b_expect(input logic [31:0] a, input logic [2:0] op, input logic we);
        exp_t r;
        r.err   = b_illegal(op, we) | (ALIGN & b_misaligned(op, a[1:0]));
        r.rdata = (r.err || we) ? 32'h0 : b_load(shadow[a[9:2]], op, a[1:0]);
        return r;
    endfunction

    // Drives one transaction from a negedge and reports what the DUT did.
    task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                       input logic we, input exp_t e,
                       output int lat, output bit saw_en, output logic [3:0] be_o,
                       output logic [AW-1:0] ad_o, output logic [31:0] wd_o,
                       output bit busy_ok, output bit ready_after);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clock); k++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_wait got=0 want=1");
        end
        sb_q.push_back(e);
        req_addr = a; req_wdata = wd; req_memop = op; req_we = we; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0; saw_en = 0; busy_ok = 1; be_o = '0; ad_o = '0; wd_o = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (req_ready) busy_ok = 0;
            if (mem_en) begin saw_en = 1; be_o = mem_be; ad_o = mem_addr; wd_o = mem_wdata; end
            if (resp_valid) begin lat = c; break; end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout got=none want=resp_valid addr=%h", a);
            void'(sb_q.pop_back());
        end
        @(negedge clock);
        ready_after = req_ready;
        if (we && !e.err) shadow[a[9:2]] = b_store(shadow[a[9:2]], op, a[1:0], wd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({resp_valid, resp_err, mem_en, mem_be, req_ready} !== 8'h0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000000", {resp_valid, resp_err, mem_en, mem_be, req_ready});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want=0", resp_rdata, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_store_byte();
        int lat; bit en, bz, ra; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
        e = '{32'h0, 1'b0};
        run(32'h100, 32'h80FF7F01, 3'b010, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (be !== 4'b1111 || wd !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL sw_lanes got be=%b wdata=%h want be=1111 wdata=80ff7f01", be, wd);
        end
        run(32'h103, 32'hAABBCC80, 3'b000, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (be !== 4'b1000 || ad !== 14'h040 || wd !== 32'h80808080) begin
            errors++;
            $display("FAIL sb_issue got be=%b addr=%h wdata=%h want be=1000 addr=040 wdata=80808080", be, ad, wd);
        end
        checks++;
        if (lat != 2 || !bz || !ra) begin
            errors++;
            $display("FAIL sb_timing got lat=%0d busy_ok=%0d ready_t3=%0d want lat=2 busy_ok=1 ready_t3=1", lat, bz, ra);
        end
    endtask

    task automatic test_load_ext();
        int lat; bit en, bz, ra; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
        for (int i = 0; i < 6; i++) begin
            e = '{LX_EXP[i], 1'b0};
            run(LX_ADDR[i], 32'h0, LX_OP[i], 1'b0, e, lat, en, be, ad, wd, bz, ra);
            checks++;
            if (lat != 2 + LAT || !en || be !== 4'b0000 || ad !== 14'h040) begin
                errors++;
                $display("FAIL load_ext[%0d] got lat=%0d en=%0d be=%b addr=%h want lat=%0d en=1 be=0000 addr=040",
                         i, lat, en, be, ad, 2 + LAT);
            end
        end
    endtask

    task automatic test_load_latency();
        int lat; bit en, bz, ra; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
        e = '{32'h0, 1'b0};
        run(32'h10, 32'h12345678, 3'b010, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        e = '{32'h12345678, 1'b0};
        run(32'h10, 32'h0, 3'b010, 1'b0, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (lat != 2 + LAT || !bz || ad !== 14'h004) begin
            errors++;
            $display("FAIL lw_latency got lat=%0d busy_ok=%0d addr=%h want lat=%0d busy_ok=1 addr=004",
                     lat, bz, ad, 2 + LAT);
        end
    endtask

    task automatic test_misaligned();
        int lat; bit en, bz, ra; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
`ifdef DMEM_ALIGN_CHECK_EN
        e = '{32'h0, 1'b1};
        run(32'h102, 32'h0, 3'b010, 1'b0, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (lat != 1 || en) begin
            errors++;
            $display("FAIL lw_misaligned got lat=%0d en=%0d want lat=1 en=0", lat, en);
        end
        run(32'h201, 32'h1234, 3'b001, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (lat != 1 || en) begin
            errors++;
            $display("FAIL sh_misaligned got lat=%0d en=%0d want lat=1 en=0", lat, en);
        end
`else
        e = '{32'h80FF7F01, 1'b0};
        run(32'h102, 32'h0, 3'b010, 1'b0, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (lat != 2 + LAT || !en || ad !== 14'h040) begin
            errors++;
            $display("FAIL lw_misaligned got lat=%0d en=%0d addr=%h want lat=%0d en=1 addr=040", lat, en, ad, 2 + LAT);
        end
        e = '{32'h0, 1'b0};
        run(32'h201, 32'h1234, 3'b001, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (lat != 2 || be !== 4'b0011 || wd !== 32'h12341234) begin
            errors++;
            $display("FAIL sh_misaligned got lat=%0d be=%b wdata=%h want lat=2 be=0011 wdata=12341234", lat, be, wd);
        end
`endif
    endtask

    task automatic test_illegal();
        int lat; bit en, bz, ra; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
        logic [2:0] ops [3];
        logic       wes [3];
        ops = '{3'b011, 3'b111, 3'b100};
        wes = '{1'b0, 1'b0, 1'b1};
        e = '{32'h0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run(32'h100, 32'hFFFFFFFF, ops[i], wes[i], e, lat, en, be, ad, wd, bz, ra);
            checks++;
            if (lat != 1 || en) begin
                errors++;
                $display("FAIL illegal[%0d] got lat=%0d en=%0d want lat=1 en=0", i, lat, en);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit en, bz, ra, seen; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
        req_addr = 32'h10; req_memop = 3'b010; req_we = 1'b0; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({resp_valid, resp_err, mem_en, mem_be, req_ready, resp_rdata, mem_wdata, mem_addr} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got valid=%b err=%b en=%b be=%b ready=%b rdata=%h wdata=%h want all 0",
                     resp_valid, resp_err, mem_en, mem_be, req_ready, resp_rdata, mem_wdata);
        end
        reset = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clock); if (resp_valid) seen = 1; end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_noresp got=resp_valid want=none");
        end
        e = '{32'h0, 1'b0};
        run(32'h0, 32'hDEADBEEF, 3'b010, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        checks++;
        if (be !== 4'b1111 || wd !== 32'hDEADBEEF || ad !== 14'h000) begin
            errors++;
            $display("FAIL abort_sw got be=%b wdata=%h addr=%h want be=1111 wdata=deadbeef addr=000", be, wd, ad);
        end
        e = '{32'hDEADBEEF, 1'b0};
        run(32'h0, 32'h0, 3'b010, 1'b0, e, lat, en, be, ad, wd, bz, ra);
    endtask

    task automatic test_back_to_back();
        int lat; bit en, bz, ra; logic [3:0] be; logic [AW-1:0] ad; logic [31:0] wd; exp_t e;
        logic [31:0] a; logic [2:0] op; logic we; logic [1:0] off;
        for (int i = 0; i < 4; i++) begin
            e = '{32'h0, 1'b0};
            run(32'h200 + 32'(4 * i), $urandom, 3'b010, 1'b1, e, lat, en, be, ad, wd, bz, ra);
        end
        for (int i = 0; i < 16; i++) begin
            we  = 1'($urandom_range(0, 1));
            op  = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            if (!we && op == 3'd3) op = 3'd4;
            else if (!we && op == 3'd4) op = 3'd5;
            off = 2'($urandom_range(0, 3));
            if (op == 3'd1 || op == 3'd5) off[0] = 1'b0;
            if (op == 3'd2) off = 2'b00;
            a = 32'h200 + 32'(4 * $urandom_range(0, 3)) + 32'(off);
            e = b_expect(a, op, we);
            run(a, $urandom, op, we, e, lat, en, be, ad, wd, bz, ra);
            checks++;
            if (lat != (we ? 2 : 2 + LAT) || !en || !ra) begin
                errors++;
                $display("FAIL b2b[%0d] got lat=%0d en=%0d ready_after=%0d want lat=%0d en=1 ready_after=1",
                         i, lat, en, ra, we ? 2 : 2 + LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_ext();
        test_load_latency();
        test_misaligned();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        repeat (4) @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending want=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
